// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, read ports, issue port and scoreboard view.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                 we;
  logic [AW-1:0]        rd_addr;
  logic [XLEN-1:0]      rd_din;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_dout;
  logic [NRD-1:0]       rs_busy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic [NREGS-1:0]     busy_vec;

  // Pipeline side driving writes, reads and issues
  modport master (
    output we, rd_addr, rd_din, rs_addr, iss_valid, iss_addr,
    input  rs_dout, rs_busy, busy_vec
  );

  // Register file side
  modport slave (
    input  we, rd_addr, rd_din, rs_addr, iss_valid, iss_addr,
    output rs_dout, rs_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Register 0 reads as zero and never becomes busy.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs   [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW-1:0]    addr_q [NRD];

  logic wr_hit;
  logic iss_hit;

  assign wr_hit  = bus.we        && (bus.rd_addr  != '0);
  assign iss_hit = bus.iss_valid && (bus.iss_addr != '0);

  // Register array write port; entry 0 is only ever cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_hit) begin
      regs[bus.rd_addr] <= bus.rd_din;
    end
  end

  // Next scoreboard: writeback clears first, then issue sets so a same-register issue wins
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)  busy_nxt[bus.rd_addr]  = 1'b0;
    if (iss_hit) busy_nxt[bus.iss_addr] = 1'b1;
  end

  // Scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Per-port read address capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NRD; i++) addr_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NRD; i++) addr_q[i] <= bus.rs_addr[i*AW +: AW];
    end
  end

  // Read data and busy lookup straight from the array so held addresses track later writes
  always_comb begin
    bus.rs_dout = '0;
    bus.rs_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      bus.rs_dout[i*XLEN +: XLEN] = regs[addr_q[i]];
      bus.rs_busy[i]              = busy[addr_q[i]];
    end
  end

  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios on the default configuration,
// randomized traffic against a reference model on a 64-bit/16-reg/3-port build.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b0 ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) b1 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model for the swept configuration
  logic [63:0] m_regs [16];
  logic [15:0] m_busy;
  logic [3:0]  m_addr [3];

  task automatic model_clear();
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int i = 0; i < 3; i++) m_addr[i] = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) m_addr[i] = b1.rs_addr[i*4 +: 4];
      if (b1.we && b1.rd_addr != 4'd0) begin
        m_regs[b1.rd_addr] = b1.rd_din;
        m_busy[b1.rd_addr] = 1'b0;
      end
      if (b1.iss_valid && b1.iss_addr != 4'd0) m_busy[b1.iss_addr] = 1'b1;
    end
  endtask

  task automatic model_compare();
    for (int i = 0; i < 3; i++) begin
      check_eq("sweep_dout", b1.rs_dout[i*64 +: 64], m_regs[m_addr[i]]);
      check_eq("sweep_busy", 64'(b1.rs_busy[i]), 64'(m_busy[m_addr[i]]));
    end
    check_eq("sweep_busy_vec", 64'(b1.busy_vec), 64'(m_busy));
  endtask

  task automatic idle0();
    b0.we = 1'b0; b0.rd_addr = '0; b0.rd_din = '0;
    b0.iss_valid = 1'b0; b0.iss_addr = '0;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle0();
    b0.rs_addr = '0;
    b1.we = 1'b0; b1.rd_addr = '0; b1.rd_din = '0;
    b1.iss_valid = 1'b0; b1.iss_addr = '0; b1.rs_addr = '0;
    model_clear();

    // Reset values
    #12;
    check_eq("rst_dout", 64'(b0.rs_dout), 64'd0);
    check_eq("rst_rs_busy", 64'(b0.rs_busy), 64'd0);
    check_eq("rst_busy_vec", 64'(b0.busy_vec), 64'd0);
    @(negedge clk); rst = 1'b0;

    // x0: write and issue to register 0 have no effect
    b0.we = 1'b1; b0.rd_addr = 5'd0; b0.rd_din = 32'hFFFF_FFFF; b0.rs_addr = {5'd0, 5'd0};
    edge_settle();
    check_eq("x0_read", 64'(b0.rs_dout[31:0]), 64'd0);
    @(negedge clk); idle0(); b0.iss_valid = 1'b1; b0.iss_addr = 5'd0;
    edge_settle();
    check_eq("x0_busy", 64'(b0.busy_vec), 64'd0);

    // Write-first, both ports on the same register
    @(negedge clk); idle0();
    b0.we = 1'b1; b0.rd_addr = 5'd7; b0.rd_din = 32'h1234_5678; b0.rs_addr = {5'd7, 5'd7};
    edge_settle();
    check_eq("wf_p0", 64'(b0.rs_dout[31:0]),  64'h1234_5678);
    check_eq("wf_p1", 64'(b0.rs_dout[63:32]), 64'h1234_5678);
    @(negedge clk); b0.rd_din = 32'h1;
    edge_settle();
    check_eq("wf2_p0", 64'(b0.rs_dout[31:0]),  64'h1);
    check_eq("wf2_p1", 64'(b0.rs_dout[63:32]), 64'h1);

    // Scoreboard lifecycle on register 3, port 1 watching
    @(negedge clk); idle0();
    b0.iss_valid = 1'b1; b0.iss_addr = 5'd3; b0.rs_addr = {5'd3, 5'd0};
    for (int k = 0; k < 4; k++) begin
      edge_settle();
      check_eq("sb_busy_vec", 64'(b0.busy_vec[3]), 64'd1);
      check_eq("sb_rs_busy", 64'(b0.rs_busy[1]), 64'd1);
      @(negedge clk); idle0();
      if (k == 3) begin
        b0.we = 1'b1; b0.rd_addr = 5'd3; b0.rd_din = 32'hABC;
      end
    end
    edge_settle();
    check_eq("sb_clr_vec", 64'(b0.busy_vec[3]), 64'd0);
    check_eq("sb_clr_rs", 64'(b0.rs_busy[1]), 64'd0);
    check_eq("sb_clr_data", 64'(b0.rs_dout[63:32]), 64'hABC);

    // Set/clear collision on register 9: set wins, data still written
    @(negedge clk); idle0(); b0.iss_valid = 1'b1; b0.iss_addr = 5'd9;
    edge_settle();
    @(negedge clk);
    b0.we = 1'b1; b0.rd_addr = 5'd9; b0.rd_din = 32'h99;
    b0.iss_valid = 1'b1; b0.iss_addr = 5'd9; b0.rs_addr = {5'd9, 5'd9};
    edge_settle();
    check_eq("coll_busy", 64'(b0.busy_vec[9]), 64'd1);
    check_eq("coll_rs_busy", 64'(b0.rs_busy[0]), 64'd1);
    check_eq("coll_data", 64'(b0.rs_dout[31:0]), 64'h99);
    // Clear 9 while setting 10: both take effect
    @(negedge clk); b0.rd_din = 32'h77; b0.iss_addr = 5'd10;
    edge_settle();
    check_eq("diff_clr", 64'(b0.busy_vec[9]), 64'd0);
    check_eq("diff_set", 64'(b0.busy_vec[10]), 64'd1);

    // Asynchronous reset after populating register 5
    @(negedge clk); idle0();
    b0.we = 1'b1; b0.rd_addr = 5'd5; b0.rd_din = 32'hDEAD_BEEF;
    b0.iss_valid = 1'b1; b0.iss_addr = 5'd5; b0.rs_addr = {5'd5, 5'd5};
    edge_settle();
    check_eq("pre_rst_data", 64'(b0.rs_dout[31:0]), 64'hDEAD_BEEF);
    check_eq("pre_rst_busy", 64'(b0.busy_vec[5]), 64'd1);
    @(negedge clk); idle0();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_data", 64'(b0.rs_dout[31:0]), 64'd0);
    check_eq("arst_busy_vec", 64'(b0.busy_vec), 64'd0);
    // Write and issue while reset is held are discarded
    b0.we = 1'b1; b0.rd_addr = 5'd5; b0.rd_din = 32'h123;
    b0.iss_valid = 1'b1; b0.iss_addr = 5'd5;
    edge_settle();
    check_eq("rst_hold_busy", 64'(b0.busy_vec), 64'd0);
    @(negedge clk); rst = 1'b0; idle0();
    edge_settle();
    check_eq("rst_drop_data", 64'(b0.rs_dout[31:0]), 64'd0);
    check_eq("rst_drop_p1", 64'(b0.rs_dout[63:32]), 64'd0);

    // Randomized traffic on the swept configuration
    model_clear();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      b1.we        = 1'($urandom);
      b1.rd_addr   = 4'($urandom);
      b1.rd_din    = {$urandom(), $urandom()};
      b1.iss_valid = 1'($urandom);
      b1.iss_addr  = 4'($urandom);
      b1.rs_addr   = 12'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 model_clear();
        model_compare();
      end
      @(posedge clk);
      model_edge();
      #1;
      model_compare();
    end

    @(negedge clk); rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
